// File: rtl/rab_arb_pkg.sv
// Shared types for the RAB lookup arbiter: FSM states, port encoding and
// the streak-counter sizing helper used by the weighted round-robin.
package rab_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Port encoding matches the select_o polarity.
    localparam logic PORT1 = 1'b1;
    localparam logic PORT2 = 1'b0;

    function automatic int unsigned streak_width(input int unsigned w1, input int unsigned w2);
        return $clog2(((w1 > w2) ? w1 : w2) + 1);
    endfunction

endpackage

// File: rtl/rab_wrr_sel.sv
// Two-input weighted round-robin grant: picks a port from the valid pair,
// the previous grant and the current streak, and returns the next streak.
module rab_wrr_sel
    import rab_arb_pkg::*;
#(
    parameter int unsigned WEIGHT1  = 1,
    parameter int unsigned WEIGHT2  = 1,
    parameter int unsigned STREAK_W = streak_width(WEIGHT1, WEIGHT2)
) (
    input  logic                valid1_i,
    input  logic                valid2_i,
    input  logic                last_grant_i,
    input  logic [STREAK_W-1:0] streak_i,
    output logic                grant_valid_o,
    output logic                grant_o,
    output logic [STREAK_W-1:0] streak_o
);

    localparam logic [STREAK_W-1:0] W1_S   = STREAK_W'(WEIGHT1);
    localparam logic [STREAK_W-1:0] W2_S   = STREAK_W'(WEIGHT2);
    localparam logic [STREAK_W-1:0] SMAX_S = (W1_S > W2_S) ? W1_S : W2_S;
    localparam logic [STREAK_W-1:0] ONE_S  = STREAK_W'(1'b1);

    logic [STREAK_W-1:0] weight_last_s;
    logic [STREAK_W-1:0] streak_inc_s;
    logic                keep_s;

    // Grant selection; a zero streak means no prior grant, so ties go to the other port.
    always_comb begin
        weight_last_s = (last_grant_i == PORT1) ? W1_S : W2_S;
        streak_inc_s  = (streak_i >= SMAX_S) ? SMAX_S : (streak_i + ONE_S);
        keep_s        = (streak_i != {STREAK_W{1'b0}}) && (streak_i < weight_last_s);
        grant_valid_o = valid1_i | valid2_i;
        if (valid1_i && valid2_i) begin
            if (keep_s) begin
                grant_o  = last_grant_i;
                streak_o = streak_inc_s;
            end else begin
                grant_o  = ~last_grant_i;
                streak_o = ONE_S;
            end
        end else if (valid1_i) begin
            grant_o  = PORT1;
            streak_o = (last_grant_i == PORT1) ? streak_inc_s : ONE_S;
        end else if (valid2_i) begin
            grant_o  = PORT2;
            streak_o = (last_grant_i == PORT2) ? streak_inc_s : ONE_S;
        end else begin
            grant_o  = last_grant_i;
            streak_o = streak_i;
        end
    end

endmodule

// File: rtl/rab_lookup_arbiter.sv
// Shares the RAB lookup controller between the AR (port1) and AW (port2)
// address channels: grant, issue lookup, wait for outcome or timeout, respond.
module rab_lookup_arbiter
    import rab_arb_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 40,
    parameter int unsigned WEIGHT1        = 1,
    parameter int unsigned WEIGHT2        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      port1_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] port1_addr_i,
    output logic                      port1_ready_o,
    output logic                      port1_resp_valid_o,
    input  logic                      port2_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] port2_addr_i,
    output logic                      port2_ready_o,
    output logic                      port2_resp_valid_o,
    output logic                      resp_drop_o,
    output logic                      lookup_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] lookup_addr_o,
    output logic                      select_o,
    input  logic                      lookup_done_i,
    input  logic                      lookup_drop_i,
    output logic                      timeout_o,
    output logic                      busy_o
);

    localparam int unsigned STREAK_W = streak_width(WEIGHT1, WEIGHT2);
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

    arb_state_e                state_q;
    logic                      last_grant_q;
    logic [STREAK_W-1:0]       streak_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic                      select_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      lookup_valid_q;
    logic                      resp1_q;
    logic                      resp2_q;
    logic                      resp_drop_q;
    logic                      timeout_q;
    logic                      busy_q;

    logic                      grant_valid_s;
    logic                      grant_s;
    logic [STREAK_W-1:0]       streak_d;

    rab_wrr_sel #(
        .WEIGHT1  (WEIGHT1),
        .WEIGHT2  (WEIGHT2),
        .STREAK_W (STREAK_W)
    ) u_wrr_sel (
        .valid1_i      (port1_valid_i),
        .valid2_i      (port2_valid_i),
        .last_grant_i  (last_grant_q),
        .streak_i      (streak_q),
        .grant_valid_o (grant_valid_s),
        .grant_o       (grant_s),
        .streak_o      (streak_d)
    );

    // Ready is combinational so the requester sees acceptance in the grant cycle.
    always_comb begin
        if (state_q == IDLE) begin
            port1_ready_o = grant_valid_s & (grant_s == PORT1);
            port2_ready_o = grant_valid_s & (grant_s == PORT2);
        end else begin
            port1_ready_o = 1'b0;
            port2_ready_o = 1'b0;
        end
    end

    // Arbiter FSM with registered pulse outputs.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q        <= IDLE;
            last_grant_q   <= PORT2;
            streak_q       <= {STREAK_W{1'b0}};
            addr_q         <= {AXI_ADDR_WIDTH{1'b0}};
            select_q       <= PORT1;
            cnt_q          <= {CNT_W{1'b0}};
            lookup_valid_q <= 1'b0;
            resp1_q        <= 1'b0;
            resp2_q        <= 1'b0;
            resp_drop_q    <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            lookup_valid_q <= 1'b0;
            resp1_q        <= 1'b0;
            resp2_q        <= 1'b0;
            resp_drop_q    <= 1'b0;
            timeout_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_s) begin
                        addr_q         <= (grant_s == PORT1) ? port1_addr_i : port2_addr_i;
                        select_q       <= grant_s;
                        last_grant_q   <= grant_s;
                        streak_q       <= streak_d;
                        lookup_valid_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the threshold cycle takes priority over the timeout.
                    if (lookup_done_i) begin
                        resp_drop_q <= lookup_drop_i;
                        resp1_q     <= (select_q == PORT1);
                        resp2_q     <= (select_q == PORT2);
                        cnt_q       <= {CNT_W{1'b0}};
                        state_q     <= RESP;
                    end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                        resp_drop_q <= 1'b1;
                        timeout_q   <= 1'b1;
                        resp1_q     <= (select_q == PORT1);
                        resp2_q     <= (select_q == PORT2);
                        cnt_q       <= {CNT_W{1'b0}};
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1'b1);
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= {CNT_W{1'b0}};
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign port1_resp_valid_o = resp1_q;
    assign port2_resp_valid_o = resp2_q;
    assign resp_drop_o        = resp_drop_q;
    assign lookup_valid_o     = lookup_valid_q;
    assign lookup_addr_o      = addr_q;
    assign select_o           = select_q;
    assign timeout_o          = timeout_q;
    assign busy_o             = busy_q;

endmodule

// File: tb/tb_rab_lookup_arbiter.sv
// Bench for rab_lookup_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_rab_lookup_arbiter;

    localparam int AW = 40;
    localparam int MW1 = 2;
    localparam int MW2 = 1;
    localparam int MT = 4;
    localparam int SMAX = (MW1 > MW2) ? MW1 : MW2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v1 = 1'b0, v2 = 1'b0, done = 1'b0, drop = 1'b0;
    logic [AW-1:0] a1 = '0, a2 = '0;

    logic a_rdy1, a_rdy2, a_rv1, a_rv2, a_rd, a_lv, a_sel, a_to, a_busy;
    logic [AW-1:0] a_addr;
    logic b_rdy1, b_rdy2, b_rv1, b_rv2, b_rd, b_lv, b_sel, b_to, b_busy;
    logic [AW-1:0] b_addr;

    rab_lookup_arbiter #(.AXI_ADDR_WIDTH(AW), .WEIGHT1(MW1), .WEIGHT2(MW2), .TIMEOUT_CYCLES(MT)) dut_a (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .port1_valid_i(v1), .port1_addr_i(a1), .port1_ready_o(a_rdy1), .port1_resp_valid_o(a_rv1),
        .port2_valid_i(v2), .port2_addr_i(a2), .port2_ready_o(a_rdy2), .port2_resp_valid_o(a_rv2),
        .resp_drop_o(a_rd), .lookup_valid_o(a_lv), .lookup_addr_o(a_addr), .select_o(a_sel),
        .lookup_done_i(done), .lookup_drop_i(drop), .timeout_o(a_to), .busy_o(a_busy));

    rab_lookup_arbiter #(.AXI_ADDR_WIDTH(AW), .WEIGHT1(MW1), .WEIGHT2(MW2), .TIMEOUT_CYCLES(0)) dut_b (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .port1_valid_i(v1), .port1_addr_i(a1), .port1_ready_o(b_rdy1), .port1_resp_valid_o(b_rv1),
        .port2_valid_i(v2), .port2_addr_i(a2), .port2_ready_o(b_rdy2), .port2_resp_valid_o(b_rv2),
        .resp_drop_o(b_rd), .lookup_valid_o(b_lv), .lookup_addr_o(b_addr), .select_o(b_sel),
        .lookup_done_i(done), .lookup_drop_i(drop), .timeout_o(b_to), .busy_o(b_busy));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 lookup issued, 2 waiting, 3 responding.
    int m_phase, m_owner, m_last, m_run, m_wait;
    bit m_drop, m_to;
    logic [AW-1:0] m_addr;

    task automatic model_reset();
        m_phase = 0; m_owner = 1; m_last = 2; m_run = 0; m_wait = 0;
        m_drop = 1'b0; m_to = 1'b0; m_addr = '0;
    endtask

    function automatic int m_pick(input logic p1, input logic p2);
        int w;
        w = (m_last == 1) ? MW1 : MW2;
        if (p1 && p2) return (m_run > 0 && m_run < w) ? m_last : 3 - m_last;
        if (p1) return 1;
        if (p2) return 2;
        return 0;
    endfunction

    task automatic model_update();
        int g;
        case (m_phase)
            0: begin
                g = m_pick(v1, v2);
                if (g != 0) begin
                    m_run   = (g == m_last) ? ((m_run + 1 > SMAX) ? SMAX : m_run + 1) : 1;
                    m_last  = g;
                    m_owner = g;
                    m_addr  = (g == 1) ? a1 : a2;
                    m_phase = 1;
                end
            end
            1: begin m_phase = 2; m_wait = 0; end
            2: begin
                if (done) begin m_drop = drop; m_to = 1'b0; m_phase = 3; end
                else if (MT != 0 && m_wait == MT - 1) begin m_drop = 1'b1; m_to = 1'b1; m_phase = 3; end
                else m_wait++;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_model();
        int g;
        g = (m_phase == 0) ? m_pick(v1, v2) : 0;
        cmp("m_ready1", a_rdy1, g == 1);
        cmp("m_ready2", a_rdy2, g == 2);
        cmp("m_lookup_valid", a_lv, m_phase == 1);
        cmp("m_lookup_addr", a_addr, m_addr);
        cmp("m_select", a_sel, m_owner == 1);
        cmp("m_resp1", a_rv1, m_phase == 3 && m_owner == 1);
        cmp("m_resp2", a_rv2, m_phase == 3 && m_owner == 2);
        cmp("m_resp_drop", a_rd, m_phase == 3 && m_drop);
        cmp("m_timeout", a_to, m_phase == 3 && m_to);
        cmp("m_busy", a_busy, m_phase != 0);
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v1 = 1'b0; v2 = 1'b0; done = 1'b0; drop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic v1, v2, dn, dr;
        logic e_rdy1, e_rdy2, e_lv, e_sel, e_rv1, e_rv2, e_rd, e_to, e_busy;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl[5];
    int grants[6];
    int exp_grants[6];
    int ng, bad;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40'h12_3456_7000};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40'h12_3456_7000};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h12_3456_7000};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40'h12_3456_7000};
        exp_grants = '{1, 1, 2, 1, 1, 2};

        // Reset values while reset is held
        model_reset();
        #12;
        cmp("rst_busy", a_busy, 1'b0);
        cmp("rst_select", a_sel, 1'b1);
        cmp("rst_addr", a_addr, 40'h0);
        cmp("rst_lookup_valid", a_lv, 1'b0);
        cmp("rst_resp", {a_rv1, a_rv2, a_rd, a_to}, 4'h0);

        // Single port1 request, table-driven
        do_reset();
        a1 = 40'h12_3456_7000;
        a2 = 40'h00_0000_0000;
        for (int i = 0; i < 5; i++) begin
            v1 = tbl[i].v1; v2 = tbl[i].v2; done = tbl[i].dn; drop = tbl[i].dr;
            to_neg();
            cmp($sformatf("tbl%0d_ready1", i), a_rdy1, tbl[i].e_rdy1);
            cmp($sformatf("tbl%0d_ready2", i), a_rdy2, tbl[i].e_rdy2);
            cmp($sformatf("tbl%0d_lookup_valid", i), a_lv, tbl[i].e_lv);
            cmp($sformatf("tbl%0d_select", i), a_sel, tbl[i].e_sel);
            cmp($sformatf("tbl%0d_resp1", i), a_rv1, tbl[i].e_rv1);
            cmp($sformatf("tbl%0d_resp2", i), a_rv2, tbl[i].e_rv2);
            cmp($sformatf("tbl%0d_resp_drop", i), a_rd, tbl[i].e_rd);
            cmp($sformatf("tbl%0d_timeout", i), a_to, tbl[i].e_to);
            cmp($sformatf("tbl%0d_busy", i), a_busy, tbl[i].e_busy);
            cmp($sformatf("tbl%0d_addr", i), a_addr, tbl[i].e_addr);
            to_next();
        end

        // Weighted round-robin order with both ports always valid
        do_reset();
        v1 = 1'b1; v2 = 1'b1; done = 1'b1; drop = 1'b0;
        a1 = 40'h11_1111_1000; a2 = 40'h22_2222_2000;
        ng = 0;
        grants = '{0, 0, 0, 0, 0, 0};
        for (int c = 0; c < 40 && ng < 6; c++) begin
            to_neg();
            if (a_rdy1) begin grants[ng] = 1; ng++; end
            else if (a_rdy2) begin grants[ng] = 2; ng++; end
            to_next();
        end
        for (int i = 0; i < 6; i++) cmp($sformatf("wrr_grant%0d", i), grants[i], exp_grants[i]);
        v1 = 1'b0; v2 = 1'b0; done = 1'b0;

        // Port2 timeout after 4 WAIT cycles
        do_reset();
        v2 = 1'b1; a2 = 40'h0A_BCDE_F000;
        to_neg(); cmp("to_ready2", a_rdy2, 1'b1); to_next();
        v2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            to_neg(); cmp($sformatf("to_wait%0d_resp2", k), a_rv2, 1'b0); to_next();
        end
        to_neg();
        cmp("to_resp2", a_rv2, 1'b1);
        cmp("to_resp_drop", a_rd, 1'b1);
        cmp("to_timeout", a_to, 1'b1);
        cmp("to0_no_resp", b_rv2, 1'b0);
        cmp("to0_busy", b_busy, 1'b1);
        to_next();
        to_neg(); cmp("to_pulse_end", a_to, 1'b0); cmp("to_idle", a_busy, 1'b0); to_next();

        // lookup_done in ISSUE ignored
        do_reset();
        v1 = 1'b1; a1 = 40'h33_4444_5000;
        to_neg(); cmp("iss_ready1", a_rdy1, 1'b1); to_next();
        v1 = 1'b0; done = 1'b1; drop = 1'b1;
        to_neg(); cmp("iss_lookup_valid", a_lv, 1'b1); to_next();
        done = 1'b0;
        to_neg(); cmp("iss_no_resp_t2", a_rv1, 1'b0); cmp("iss_busy_t2", a_busy, 1'b1); to_next();
        done = 1'b1; drop = 1'b0;
        to_neg(); cmp("iss_no_resp_t3", a_rv1, 1'b0); to_next();
        done = 1'b0;
        to_neg(); cmp("iss_resp1", a_rv1, 1'b1); cmp("iss_resp_drop", a_rd, 1'b0); cmp("iss_timeout", a_to, 1'b0); to_next();

        // Asynchronous reset during WAIT
        do_reset();
        v2 = 1'b1; a2 = 40'h55_6666_7000;
        to_neg(); to_next();
        v2 = 1'b0;
        to_neg(); to_next();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp("arst_busy", a_busy, 1'b0);
        cmp("arst_select", a_sel, 1'b1);
        cmp("arst_addr", a_addr, 40'h0);
        cmp("arst_outs", {a_lv, a_rv1, a_rv2, a_rd, a_to}, 5'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        v2 = 1'b1; a2 = 40'h77_8888_9000;
        to_neg(); cmp("arst_ready2", a_rdy2, 1'b1); cmp("arst_no_stale", {a_rv1, a_rv2}, 2'b00); to_next();
        v2 = 1'b0;
        to_neg(); cmp("arst_lv", a_lv, 1'b1); cmp("arst_sel2", a_sel, 1'b0); cmp("arst_addr2", a_addr, 40'h77_8888_9000); to_next();
        done = 1'b1; drop = 1'b1;
        to_neg(); cmp("arst_wait_no_resp", {a_rv1, a_rv2}, 2'b00); to_next();
        done = 1'b0;
        to_neg(); cmp("arst_resp2", a_rv2, 1'b1); cmp("arst_resp_drop", a_rd, 1'b1); to_next();

        // Timeout disabled: wait 1000 cycles then done
        do_reset();
        v1 = 1'b1; a1 = 40'h99_AAAA_B000;
        to_neg(); to_next();
        v1 = 1'b0;
        to_neg(); to_next();
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            to_neg();
            if (b_busy !== 1'b1 || b_rv1 !== 1'b0 || b_to !== 1'b0) bad++;
            to_next();
        end
        cmp("to0_hold_wait", bad, 0);
        done = 1'b1; drop = 1'b0;
        to_neg(); to_next();
        done = 1'b0;
        to_neg(); cmp("to0_resp1", b_rv1, 1'b1); cmp("to0_resp_drop", b_rd, 1'b0); cmp("to0_timeout", b_to, 1'b0); to_next();
        to_neg(); cmp("to0_idle", b_busy, 1'b0); to_next();

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            v1 = ($urandom_range(0, 2) != 0);
            v2 = ($urandom_range(0, 2) != 0);
            a1 = {$urandom, $urandom};
            a2 = {$urandom, $urandom};
            done = ($urandom_range(0, 3) == 0);
            drop = $urandom_range(0, 1);
            to_neg();
            check_model();
            to_next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
